// File: rtl/rhs_axil_cfg_regs_if.sv
// AXI4-Lite bundle between the PS/VIP master and the RHS config register file.
interface rhs_axil_cfg_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rhs_axil_cfg_regs.sv
// AXI4-Lite register file for the RHS stimulation controller: eight config words,
// command pulses on reg0 writes, and engine status merged into reg0 reads.
module rhs_axil_cfg_regs #(
  parameter int C_ADDR_WIDTH = 5,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                rhs_aclk,
  input  logic                rhs_areset,
  rhs_axil_cfg_regs_if.slave  s_axi,
  input  logic                eng_busy,
  output logic                cmd_start,
  output logic                cmd_stop,
  output logic [2:0]          cmd_op,
  output logic                loopback,
  output logic                man_dly_en,
  output logic [3:0]          man_dly,
  output logic [7:0]          pos_mag,
  output logic [7:0]          pos_trim,
  output logic [7:0]          neg_mag,
  output logic [7:0]          neg_trim,
  output logic [7:0]          pkt_len,
  output logic [1:0]          z_scale,
  output logic [7:0]          z_cycle,
  output logic [15:0]         stim_mask,
  output logic                stim_pol,
  output logic                stim_bipolar,
  output logic [3:0]          stim_ch_n,
  output logic [3:0]          stim_ch_p,
  output logic [15:0]         pulse_width,
  output logic [15:0]         ipulse_dly,
  output logic [10:0]         num_pulse
);

  typedef enum logic {W_IDLE, W_RESP} wState_e;
  typedef enum logic {R_IDLE, R_DATA} rState_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  wState_e                 wState_q;
  rState_e                 rState_q;
  logic [C_ADDR_WIDTH-1:0] awAddr_q;
  logic [C_DATA_WIDTH-1:0] wData_q;
  logic [3:0]              wStrb_q;
  logic                    awDone_q, wDone_q;
  logic                    awReady_q, wReady_q, bValid_q;
  logic [1:0]              bResp_q;
  logic                    arReady_q, rValid_q;
  logic [1:0]              rResp_q;
  logic [C_DATA_WIDTH-1:0] rData_q;
  logic [31:0]             regs_q [8];
  logic                    cmdStart_q, cmdStop_q;

  logic [2:0]              wIdx, rIdx;
  logic [31:0]             laneMask, wrValue_d, rdValue_d;
  logic                    wrErr, rdErr;

  // Implemented bits per word; everything else is stored and read back as zero.
  function automatic logic [31:0] fieldMask(input logic [2:0] idx);
    case (idx)
      3'd0:    fieldMask = 32'h0000_07FF;
      3'd1:    fieldMask = 32'hFFFF_FFFF;
      3'd2:    fieldMask = 32'h0000_00FF;
      3'd3:    fieldMask = 32'h0000_03FF;
      3'd4:    fieldMask = 32'h03FF_FFFF;
      3'd5:    fieldMask = 32'h0000_FFFF;
      3'd6:    fieldMask = 32'h0000_FFFF;
      default: fieldMask = 32'h0000_07FF;
    endcase
  endfunction

  always_comb begin
    wIdx      = awAddr_q[4:2];
    laneMask  = {{8{wStrb_q[3]}}, {8{wStrb_q[2]}}, {8{wStrb_q[1]}}, {8{wStrb_q[0]}}};
    wrValue_d = ((regs_q[wIdx] & ~laneMask) | (wData_q & laneMask)) & fieldMask(wIdx);
    // reg0 stays writable while busy so software can always issue a stop.
    wrErr     = (awAddr_q[1:0] != 2'b00) || ((wIdx != 3'd0) && eng_busy);
  end

  always_comb begin
    rIdx      = s_axi.araddr[4:2];
    rdErr     = (s_axi.araddr[1:0] != 2'b00);
    rdValue_d = regs_q[rIdx];
    if (rdErr) begin
      rdValue_d = '0;
    end else if (rIdx == 3'd0) begin
      rdValue_d = {eng_busy, 20'b0, regs_q[0][10:0]};
    end
  end

  always_ff @(posedge rhs_aclk) begin
    if (rhs_areset) begin
      wState_q   <= W_IDLE;
      awAddr_q   <= '0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      awReady_q  <= 1'b1;
      wReady_q   <= 1'b1;
      bValid_q   <= 1'b0;
      bResp_q    <= RESP_OKAY;
      cmdStart_q <= 1'b0;
      cmdStop_q  <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      cmdStart_q <= 1'b0;
      cmdStop_q  <= 1'b0;
      case (wState_q)
        W_IDLE: begin
          if (s_axi.awvalid && awReady_q) begin
            awAddr_q  <= s_axi.awaddr;
            awDone_q  <= 1'b1;
            awReady_q <= 1'b0;
          end
          if (s_axi.wvalid && wReady_q) begin
            wData_q  <= s_axi.wdata;
            wStrb_q  <= s_axi.wstrb;
            wDone_q  <= 1'b1;
            wReady_q <= 1'b0;
          end
          if (awDone_q && wDone_q) begin
            wState_q <= W_RESP;
            bValid_q <= 1'b1;
            if (wrErr) begin
              bResp_q <= RESP_SLVERR;
            end else begin
              bResp_q      <= RESP_OKAY;
              regs_q[wIdx] <= wrValue_d;
              if (wIdx == 3'd0) begin
                cmdStart_q <= wrValue_d[0];
                cmdStop_q  <= ~wrValue_d[0] & eng_busy;
              end
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            wState_q  <= W_IDLE;
            bValid_q  <= 1'b0;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
          end
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Read data is captured at the AR handshake, so a write committing later reads as old.
  always_ff @(posedge rhs_aclk) begin
    if (rhs_areset) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b1;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (s_axi.arvalid && arReady_q) begin
            rState_q  <= R_DATA;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b1;
            rData_q   <= rdValue_d;
            rResp_q   <= rdErr ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rState_q  <= R_IDLE;
            arReady_q <= 1'b1;
            rValid_q  <= 1'b0;
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awReady_q;
  assign s_axi.wready  = wReady_q;
  assign s_axi.bvalid  = bValid_q;
  assign s_axi.bresp   = bResp_q;
  assign s_axi.arready = arReady_q;
  assign s_axi.rvalid  = rValid_q;
  assign s_axi.rdata   = rData_q;
  assign s_axi.rresp   = rResp_q;

  assign cmd_start    = cmdStart_q;
  assign cmd_stop     = cmdStop_q;
  assign cmd_op       = regs_q[0][3:1];
  assign loopback     = regs_q[0][5];
  assign man_dly_en   = regs_q[0][6];
  assign man_dly      = regs_q[0][10:7];
  assign pos_mag      = regs_q[1][31:24];
  assign pos_trim     = regs_q[1][23:16];
  assign neg_mag      = regs_q[1][15:8];
  assign neg_trim     = regs_q[1][7:0];
  assign pkt_len      = regs_q[2][7:0];
  assign z_scale      = regs_q[3][9:8];
  assign z_cycle      = regs_q[3][7:0];
  assign stim_mask    = regs_q[4][25:10];
  assign stim_pol     = regs_q[4][9];
  assign stim_bipolar = regs_q[4][8];
  assign stim_ch_n    = regs_q[4][7:4];
  assign stim_ch_p    = regs_q[4][3:0];
  assign pulse_width  = regs_q[5][15:0];
  assign ipulse_dly   = regs_q[6][15:0];
  assign num_pulse    = regs_q[7][10:0];

endmodule

// File: tb/tb_rhs_axil_cfg_regs.sv
// Self-checking bench for rhs_axil_cfg_regs: directed scenarios plus random traffic
// checked against a word-level model of the register map.
module tb_rhs_axil_cfg_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        eng_busy;
  logic        cmd_start, cmd_stop;
  logic [2:0]  cmd_op;
  logic        loopback, man_dly_en;
  logic [3:0]  man_dly;
  logic [7:0]  pos_mag, pos_trim, neg_mag, neg_trim, pkt_len;
  logic [1:0]  z_scale;
  logic [7:0]  z_cycle;
  logic [15:0] stim_mask;
  logic        stim_pol, stim_bipolar;
  logic [3:0]  stim_ch_n, stim_ch_p;
  logic [15:0] pulse_width, ipulse_dly;
  logic [10:0] num_pulse;

  rhs_axil_cfg_regs_if bus ();

  rhs_axil_cfg_regs dut (
    .rhs_aclk     (clk),
    .rhs_areset   (rst),
    .s_axi        (bus),
    .eng_busy     (eng_busy),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_op       (cmd_op),
    .loopback     (loopback),
    .man_dly_en   (man_dly_en),
    .man_dly      (man_dly),
    .pos_mag      (pos_mag),
    .pos_trim     (pos_trim),
    .neg_mag      (neg_mag),
    .neg_trim     (neg_trim),
    .pkt_len      (pkt_len),
    .z_scale      (z_scale),
    .z_cycle      (z_cycle),
    .stim_mask    (stim_mask),
    .stim_pol     (stim_pol),
    .stim_bipolar (stim_bipolar),
    .stim_ch_n    (stim_ch_n),
    .stim_ch_p    (stim_ch_p),
    .pulse_width  (pulse_width),
    .ipulse_dly   (ipulse_dly),
    .num_pulse    (num_pulse)
  );

  int errors = 0;
  int checks = 0;
  int startCnt = 0;
  int stopCnt = 0;
  int bHsCnt = 0;
  logic [31:0] model [8];

  // Pulses and B handshakes are counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmd_start) startCnt++;
    if (cmd_stop) stopCnt++;
    if (bus.bvalid && bus.bready) bHsCnt++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] implMask(input int idx);
    int bits;
    case (idx)
      0: bits = 11;
      1: bits = 32;
      2: bits = 8;
      3: bits = 10;
      4: bits = 26;
      5: bits = 16;
      6: bits = 16;
      default: bits = 11;
    endcase
    implMask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic modelWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic busy, output logic [1:0] resp, output logic expStart,
                            output logic expStop);
    int idx;
    logic [31:0] newv;
    idx = addr / 4;
    expStart = 1'b0;
    expStop = 1'b0;
    if ((addr % 4) != 0 || (idx != 0 && busy)) begin
      resp = 2'b10;
    end else begin
      newv = model[idx];
      for (int b = 0; b < 4; b++)
        if (strb[b]) newv[b*8 +: 8] = data[b*8 +: 8];
      model[idx] = newv & implMask(idx);
      resp = 2'b00;
      if (idx == 0) begin
        expStart = model[0][0];
        expStop = !model[0][0] && busy;
      end
    end
  endtask

  function automatic logic [31:0] modelRead(input int idx, input logic busy);
    modelRead = (idx == 0) ? ({busy, 31'b0} | model[0]) : model[idx];
  endfunction

  function automatic logic [127:0] fieldsObs();
    fieldsObs = {cmd_op, loopback, man_dly_en, man_dly, pos_mag, pos_trim, neg_mag, neg_trim,
                 pkt_len, z_scale, z_cycle, stim_mask, stim_pol, stim_bipolar, stim_ch_n,
                 stim_ch_p, pulse_width, ipulse_dly, num_pulse};
  endfunction

  function automatic logic [127:0] fieldsExp();
    fieldsExp = {model[0][3:1], model[0][5], model[0][6], model[0][10:7], model[1],
                 model[2][7:0], model[3][9:0], model[4][25:10], model[4][9], model[4][8],
                 model[4][7:4], model[4][3:0], model[5][15:0], model[6][15:0], model[7][10:0]};
  endfunction

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat);
    int cyc;
    logic awHs, wHs;
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    cyc = 0;
    while ((bus.awvalid || bus.wvalid) && cyc < 50) begin
      awHs = bus.awvalid && bus.awready;
      wHs = bus.wvalid && bus.wready;
      tick();
      if (awHs) bus.awvalid = 1'b0;
      if (wHs) bus.wvalid = 1'b0;
      cyc++;
    end
    lat = 0;
    while (!bus.bvalid && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus.bvalid) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_timeout addr=%h: got bvalid=0, expected 1", addr);
    end
    resp = bus.bresp;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axiRead(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    logic done;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 50) begin
      done = bus.arready;
      tick();
      cyc++;
    end
    bus.arvalid = 1'b0;
    while (!bus.rvalid && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!bus.rvalid) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout addr=%h: got rvalid=0, expected 1", addr);
    end
    data = bus.rdata;
    resp = bus.rresp;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelClear();
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_readies: got %b, expected 111", {bus.awready, bus.wready, bus.arready});
    end
    checks++;
    if ({bus.bvalid, bus.rvalid, cmd_start, cmd_stop, bus.bresp, bus.rresp} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_valids: got %h, expected 00",
               {bus.bvalid, bus.rvalid, cmd_start, cmd_stop, bus.bresp, bus.rresp});
    end
    checks++;
    if (fieldsObs() !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_fields: got %h, expected 0", fieldsObs());
    end
  endtask

  task automatic test_reg_fields();
    logic [1:0] resp, expResp;
    logic [31:0] rd;
    logic es, ep;
    int lat;
    eng_busy = 1'b0;
    modelWrite(5'h04, 32'h80FF80FF, 4'hF, 1'b0, expResp, es, ep);
    axiWrite(5'h04, 32'h80FF80FF, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b00 || lat !== 1) begin
      errors++;
      $display("[TB] FAIL wr04_resp_latency: got resp=%b lat=%0d, expected resp=00 lat=1", resp, lat);
    end
    axiRead(5'h04, rd, resp);
    checks++;
    if (rd !== 32'h80FF80FF || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd04: got %h/%b, expected 80ff80ff/00", rd, resp);
    end
    checks++;
    if ({pos_mag, pos_trim, neg_mag, neg_trim} !== 32'h80FF80FF) begin
      errors++;
      $display("[TB] FAIL mag_trim_fields: got %h, expected 80ff80ff", {pos_mag, pos_trim, neg_mag, neg_trim});
    end
    modelWrite(5'h10, 32'h010007F0, 4'hF, 1'b0, expResp, es, ep);
    axiWrite(5'h10, 32'h010007F0, 4'hF, resp, lat);
    checks++;
    if ({stim_mask, stim_pol, stim_bipolar, stim_ch_n, stim_ch_p} !== {16'h4001, 1'b1, 1'b1, 4'hF, 4'h0}) begin
      errors++;
      $display("[TB] FAIL stim_fields: got %h, expected %h",
               {stim_mask, stim_pol, stim_bipolar, stim_ch_n, stim_ch_p}, {16'h4001, 1'b1, 1'b1, 4'hF, 4'h0});
    end
    axiRead(5'h10, rd, resp);
    checks++;
    if (rd !== 32'h010007F0 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rd10: got %h/%b, expected 010007f0/00", rd, resp);
    end
  endtask

  task automatic test_commands();
    logic [1:0] resp, expResp;
    logic [31:0] rd;
    logic es, ep;
    int lat, s0, p0;
    eng_busy = 1'b0;
    s0 = startCnt;
    p0 = stopCnt;
    modelWrite(5'h00, 32'h29, 4'hF, 1'b0, expResp, es, ep);
    axiWrite(5'h00, 32'h29, 4'hF, resp, lat);
    checks++;
    if (startCnt - s0 != 1 || stopCnt - p0 != 0 || cmd_op !== 3'd4 || loopback !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_cmd: got starts=%0d stops=%0d op=%0d lb=%b, expected 1 0 4 1",
               startCnt - s0, stopCnt - p0, cmd_op, loopback);
    end
    s0 = startCnt;
    axiWrite(5'h00, 32'h29, 4'hF, resp, lat);
    checks++;
    if (startCnt - s0 != 1) begin
      errors++;
      $display("[TB] FAIL repeat_start: got %0d pulses, expected 1", startCnt - s0);
    end
    eng_busy = 1'b1;
    s0 = startCnt;
    p0 = stopCnt;
    modelWrite(5'h00, 32'h0, 4'hF, 1'b1, expResp, es, ep);
    axiWrite(5'h00, 32'h0, 4'hF, resp, lat);
    checks++;
    if (startCnt - s0 != 0 || stopCnt - p0 != 1 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stop_cmd: got starts=%0d stops=%0d resp=%b, expected 0 1 00",
               startCnt - s0, stopCnt - p0, resp);
    end
    axiRead(5'h00, rd, resp);
    checks++;
    if (rd !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL rd00_busy: got %h, expected 80000000", rd);
    end
    eng_busy = 1'b0;
    p0 = stopCnt;
    axiWrite(5'h00, 32'h0, 4'hF, resp, lat);
    checks++;
    if (stopCnt - p0 != 0) begin
      errors++;
      $display("[TB] FAIL idle_clear_no_stop: got %0d stops, expected 0", stopCnt - p0);
    end
  endtask

  task automatic test_busy_reject();
    logic [1:0] resp, expResp;
    logic [31:0] rd;
    logic es, ep;
    int lat;
    eng_busy = 1'b1;
    modelWrite(5'h14, 32'h5, 4'hF, 1'b1, expResp, es, ep);
    axiWrite(5'h14, 32'h5, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10 || pulse_width !== 16'h0) begin
      errors++;
      $display("[TB] FAIL busy_write: got resp=%b pw=%h, expected 10/0000", resp, pulse_width);
    end
    eng_busy = 1'b0;
    modelWrite(5'h14, 32'h5, 4'hF, 1'b0, expResp, es, ep);
    axiWrite(5'h14, 32'h5, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b00 || pulse_width !== 16'h5) begin
      errors++;
      $display("[TB] FAIL idle_write: got resp=%b pw=%h, expected 00/0005", resp, pulse_width);
    end
    axiWrite(5'h15, 32'hFFFF, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10 || pulse_width !== 16'h5) begin
      errors++;
      $display("[TB] FAIL misaligned_write: got resp=%b pw=%h, expected 10/0005", resp, pulse_width);
    end
    axiRead(5'h16, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== 2'b10) begin
      errors++;
      $display("[TB] FAIL misaligned_read: got %h/%b, expected 00000000/10", rd, resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expResp;
    logic es, ep, stuck;
    logic [31:0] data2;
    int b0;
    eng_busy = 1'b0;
    b0 = bHsCnt;
    bus.bready = 1'b0;
    bus.awaddr = 5'h08;
    bus.wdata = 32'h0000_00A5;
    bus.wstrb = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    checks++;
    if ({bus.awready, bus.wready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL w_first_readies: got %b, expected 10", {bus.awready, bus.wready});
    end
    tick();
    tick();
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    modelWrite(5'h08, 32'h0000_00A5, 4'hF, 1'b0, expResp, es, ep);
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bvalid_early: got %b, expected 0", bus.bvalid);
    end
    tick();
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || pkt_len !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL w_first_commit: got bvalid=%b bresp=%b pkt=%h, expected 1 00 a5",
               bus.bvalid, bus.bresp, pkt_len);
    end
    data2 = $urandom;
    bus.awaddr = 5'h0C;
    bus.wdata = data2;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    stuck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.awready || bus.wready || !bus.bvalid) stuck = 1'b1;
      tick();
    end
    checks++;
    if (stuck !== 1'b0 || {z_scale, z_cycle} !== model[3][9:0]) begin
      errors++;
      $display("[TB] FAIL hold_b: got accepted=%b z=%h, expected 0 %h", stuck, {z_scale, z_cycle}, model[3][9:0]);
    end
    bus.bready = 1'b1;
    tick();
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    modelWrite(5'h0C, data2, 4'hF, 1'b0, expResp, es, ep);
    tick();
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || {z_scale, z_cycle} !== model[3][9:0]) begin
      errors++;
      $display("[TB] FAIL second_write: got bvalid=%b z=%h, expected 1 %h", bus.bvalid, {z_scale, z_cycle}, model[3][9:0]);
    end
    tick();
    bus.bready = 1'b0;
    checks++;
    if (bHsCnt - b0 != 2) begin
      errors++;
      $display("[TB] FAIL b_count: got %0d, expected 2", bHsCnt - b0);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] wResp, rResp, expResp;
    logic [31:0] rd, pre, data;
    logic es, ep;
    int lat;
    eng_busy = 1'b0;
    pre = model[6];
    data = $urandom;
    fork
      axiWrite(5'h18, data, 4'hF, wResp, lat);
      axiRead(5'h18, rd, rResp);
    join
    modelWrite(5'h18, data, 4'hF, 1'b0, expResp, es, ep);
    checks++;
    if (rd !== pre || rResp !== 2'b00 || ipulse_dly !== model[6][15:0]) begin
      errors++;
      $display("[TB] FAIL simultaneous: got rd=%h dly=%h, expected rd=%h dly=%h", rd, ipulse_dly, pre, model[6][15:0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, rResp, expResp, lo;
    logic [2:0] idx;
    logic [4:0] addr;
    logic [31:0] data, rd, exp;
    logic [3:0] strb;
    logic busy, es, ep;
    int lat, s0, p0;
    for (int i = 0; i < 40; i++) begin
      idx = 3'($urandom_range(0, 7));
      lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr = {idx, lo};
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      busy = ($urandom_range(0, 2) == 0);
      eng_busy = busy;
      s0 = startCnt;
      p0 = stopCnt;
      modelWrite(addr, data, strb, busy, expResp, es, ep);
      axiWrite(addr, data, strb, resp, lat);
      checks++;
      if (resp !== expResp || (startCnt - s0) != int'(es) || (stopCnt - p0) != int'(ep)) begin
        errors++;
        $display("[TB] FAIL rand_write[%0d] addr=%h: got resp=%b start=%0d stop=%0d, expected %b %0d %0d",
                 i, addr, resp, startCnt - s0, stopCnt - p0, expResp, es, ep);
      end
      axiRead({idx, 2'b00}, rd, rResp);
      exp = modelRead(int'(idx), busy);
      checks++;
      if (rd !== exp || rResp !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rand_read[%0d] idx=%0d: got %h/%b, expected %h/00", i, idx, rd, rResp, exp);
      end
    end
    eng_busy = 1'b0;
    checks++;
    if (fieldsObs() !== fieldsExp()) begin
      errors++;
      $display("[TB] FAIL rand_fields: got %h, expected %h", fieldsObs(), fieldsExp());
    end
  endtask

  task automatic test_strobe_reset();
    logic [1:0] resp, expResp;
    logic [31:0] rd;
    logic es, ep;
    int lat;
    eng_busy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelClear();
    modelWrite(5'h1C, 32'hFFFF_FFFF, 4'b0001, 1'b0, expResp, es, ep);
    axiWrite(5'h1C, 32'hFFFF_FFFF, 4'b0001, resp, lat);
    checks++;
    if (num_pulse !== 11'h0FF || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL strobe_byte0: got np=%h resp=%b, expected 0ff 00", num_pulse, resp);
    end
    modelWrite(5'h04, 32'h1234_5678, 4'hF, 1'b0, expResp, es, ep);
    axiWrite(5'h04, 32'h1234_5678, 4'hF, resp, lat);
    bus.araddr = 5'h1C;
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0000_00FF) begin
      errors++;
      $display("[TB] FAIL r_data_hold: got rvalid=%b rdata=%h, expected 1 000000ff", bus.rvalid, bus.rdata);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelClear();
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || fieldsObs() !== 128'h0) begin
      errors++;
      $display("[TB] FAIL mid_read_reset: got rvalid=%b arready=%b fields=%h, expected 0 1 0",
               bus.rvalid, bus.arready, fieldsObs());
    end
    axiRead(5'h04, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_reset_read: got %h/%b, expected 00000000/00", rd, resp);
    end
  endtask

  initial begin
    rst = 1'b1;
    eng_busy = 1'b0;
    bus.awaddr = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    modelClear();
    tick();
    test_reset();
    test_reg_fields();
    test_commands();
    test_busy_reject();
    test_back_to_back();
    test_simultaneous();
    test_random();
    test_strobe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
